// File: rtl/encoder_frame_ctrl.sv
// encoder_frame_ctrl
//
// Word-serial front/back end and sequencer for the 1600-bit encoder core.
// Collects 64 x 25-bit lanes from an input stream into a packed buffer, pulses the
// encoder start, waits (with a timeout) for the encoder's Ready, captures the
// 1600-bit result and streams it back out as 64 x 25-bit words.
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_reset          synchronous active-high reset
//   i_in_valid       input word valid
//   o_in_ready       block accepts an input word this cycle (LOAD only)
//   i_in_data        input lane word (25 bits)
//   o_out_valid      result word valid (UNLOAD only)
//   i_out_ready      downstream accepts a result word
//   o_out_data       result lane word (25 bits)
//   o_enc_start      encoder start, high for START_CYCLES cycles per frame
//   o_enc_raw_data   encoder raw_data, the registered input buffer (1600 bits)
//   i_enc_encoded    encoder result (1600 bits)
//   i_enc_ready      encoder Ready
//   o_frame_done     one-cycle pulse on the last output handshake
//   o_busy           high except when idle in LOAD with no words collected
//   o_err_timeout    sticky timeout flag, cleared only by reset
module encoder_frame_ctrl #(
    parameter int unsigned START_CYCLES  = 1,
    parameter int unsigned IGNORE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [24:0]   i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [24:0]   o_out_data,
    output logic          o_enc_start,
    output logic [1599:0] o_enc_raw_data,
    input  logic [1599:0] i_enc_encoded,
    input  logic          i_enc_ready,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_err_timeout
);

    localparam logic [15:0] StartLast   = 16'(START_CYCLES - 1);
    localparam logic [15:0] IgnoreLast  = 16'(IGNORE_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StArm,
        StWait,
        StUnload
    } state_t;

    state_t          r_state;
    logic [5:0]      r_idx;
    logic [15:0]     r_timer;
    logic            r_err;
    logic [1599:0]   r_ibuf;
    logic [1599:0]   r_obuf;

    logic [10:0]     w_base;
    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_capture;

    // Outputs are decoded from the registered state; reset forces them idle even
    // in the cycle where reset is first seen.
    assign o_in_ready     = (r_state == StLoad) & ~i_reset;
    assign o_out_valid    = (r_state == StUnload) & ~i_reset;
    assign o_enc_start    = (r_state == StStart) & ~i_reset;
    assign o_err_timeout  = r_err & ~i_reset;
    assign o_busy         = ~i_reset & ~((r_state == StLoad) && (r_idx == 6'd0));
    assign o_enc_raw_data = r_ibuf;

    assign w_base     = 11'(r_idx) * 11'd25;
    assign w_in_hs    = o_in_ready & i_in_valid;
    assign w_out_hs   = o_out_valid & i_out_ready;
    assign w_capture  = (r_state == StWait) & i_enc_ready;

    assign o_out_data   = r_obuf[w_base +: 25];
    assign o_frame_done = w_out_hs && (r_idx == 6'd63);

    // Data buffers carry no reset: their contents are meaningless until written.
    always_ff @(posedge i_clk) begin
        if (w_in_hs) begin
            r_ibuf[w_base +: 25] <= i_in_data;
        end
        if (w_capture) begin
            r_obuf <= i_enc_encoded;
        end
    end

    // One counter serves the START hold, the ARM ignore window and the WAIT timeout;
    // it is always zero on entry to each of those states.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StLoad;
            r_idx   <= 6'd0;
            r_timer <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (w_in_hs) begin
                        r_idx <= r_idx + 6'd1;
                        if (r_idx == 6'd63) begin
                            r_state <= StStart;
                            r_timer <= 16'd0;
                        end
                    end
                end
                StStart: begin
                    if (r_timer == StartLast) begin
                        r_timer <= 16'd0;
                        r_state <= (IGNORE_CYCLES == 0) ? StWait : StArm;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                StArm: begin
                    // Ready may still be high from the previous frame; do not look.
                    if (r_timer == IgnoreLast) begin
                        r_timer <= 16'd0;
                        r_state <= StWait;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                StWait: begin
                    // Ready wins over a coincident timeout.
                    if (i_enc_ready) begin
                        r_timer <= 16'd0;
                        r_state <= StUnload;
                    end else if (r_timer == TimeoutLast) begin
                        r_timer <= 16'd0;
                        r_err   <= 1'b1;
                        r_state <= StLoad;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                StUnload: begin
                    if (w_out_hs) begin
                        r_idx <= r_idx + 6'd1;
                        if (r_idx == 6'd63) begin
                            r_state <= StLoad;
                        end
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

endmodule
